// File: rtl/bsg_nasti_mem_model.sv
// NASTI (AXI4) slave memory model: independent single-outstanding write and
// read engines over a byte-enabled word array, with optional LFSR backpressure.
module bsg_nasti_mem_model #(
  parameter int          data_width_p = 64,
  parameter int          addr_width_p = 32,
  parameter int          id_width_p   = 6,
  parameter int          els_p        = 1024,
  parameter int          stall_mode_p = 0,
  parameter logic [15:0] lfsr_seed_p  = 16'hACE1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      aw_valid_i,
  output logic                      aw_ready_o,
  input  logic [addr_width_p-1:0]   aw_addr_i,
  input  logic [7:0]                aw_len_i,
  input  logic [2:0]                aw_size_i,
  input  logic [1:0]                aw_burst_i,
  input  logic [id_width_p-1:0]     aw_id_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [data_width_p-1:0]   w_data_i,
  input  logic [data_width_p/8-1:0] w_strb_i,
  input  logic                      w_last_i,
  output logic                      b_valid_o,
  input  logic                      b_ready_i,
  output logic [1:0]                b_resp_o,
  output logic [id_width_p-1:0]     b_id_o,
  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  input  logic [addr_width_p-1:0]   ar_addr_i,
  input  logic [7:0]                ar_len_i,
  input  logic [2:0]                ar_size_i,
  input  logic [1:0]                ar_burst_i,
  input  logic [id_width_p-1:0]     ar_id_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [data_width_p-1:0]   r_data_o,
  output logic [1:0]                r_resp_o,
  output logic                      r_last_o,
  output logic [id_width_p-1:0]     r_id_o
);

  localparam int bytes_lp     = data_width_p / 8;
  localparam int lg_bytes_lp  = $clog2(bytes_lp);
  localparam int idx_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [2:0] size_lp = 3'(lg_bytes_lp);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [data_width_p-1:0] mem [els_p];
  logic [15:0] lfsr;
  logic        stall_ok;

  // Next beat address for FIXED, INCR (and reserved type 3) and WRAP bursts.
  function automatic logic [addr_width_p-1:0] next_addr(
    input logic [addr_width_p-1:0] addr,
    input logic [7:0]              len,
    input logic [1:0]              burst
  );
    logic [addr_width_p-1:0] inc;
    logic [addr_width_p-1:0] mask;
    inc  = addr + addr_width_p'(bytes_lp);
    mask = ((addr_width_p'(len) + addr_width_p'(1)) << lg_bytes_lp) - addr_width_p'(1);
    case (burst)
      2'd0:    next_addr = addr;
      2'd2:    next_addr = (addr & ~mask) | (inc & mask);
      default: next_addr = inc;
    endcase
  endfunction

  function automatic logic in_range(input logic [addr_width_p-1:0] addr);
    in_range = (addr >> lg_bytes_lp) < addr_width_p'(els_p);
  endfunction

  function automatic logic [idx_width_lp-1:0] word_idx(input logic [addr_width_p-1:0] addr);
    word_idx = addr[lg_bytes_lp +: idx_width_lp];
  endfunction

  // Free-running Fibonacci LFSR (taps 16,14,13,11) used as a ready gate.
  always_ff @(posedge clk_i) begin
    if (reset_i) lfsr <= lfsr_seed_p;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall_ok = (stall_mode_p == 0) | lfsr[0];

  // ---------------- write path ----------------
  w_state_e w_state, w_state_n;
  logic [addr_width_p-1:0] w_addr;
  logic [7:0]              w_len, w_cnt;
  logic [1:0]              w_burst;
  logic [id_width_p-1:0]   w_id;
  logic                    w_size_ok, w_slv, w_dec;
  logic                    aw_hs, w_hs, w_final;

  assign w_final = (w_cnt == w_len);
  assign aw_hs   = aw_valid_i & aw_ready_o;
  assign w_hs    = w_valid_i & w_ready_o;

  // Write state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) w_state <= W_IDLE;
    else         w_state <= w_state_n;
  end

  // Write next-state and handshake outputs; everything is held off during reset.
  always_comb begin
    w_state_n  = w_state;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    if (!reset_i) begin
      case (w_state)
        W_IDLE: begin
          aw_ready_o = stall_ok;
          if (aw_valid_i && stall_ok) w_state_n = W_DATA;
        end
        W_DATA: begin
          w_ready_o = stall_ok;
          if (w_valid_i && stall_ok && w_final) w_state_n = W_RESP;
        end
        W_RESP: begin
          b_valid_o = 1'b1;
          if (b_ready_i) w_state_n = W_IDLE;
        end
        default: w_state_n = W_IDLE;
      endcase
    end
  end

  // Latch the write burst, then walk the address and collect error flags per beat.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_addr    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_burst   <= '0;
      w_id      <= '0;
      w_size_ok <= 1'b0;
      w_slv     <= 1'b0;
      w_dec     <= 1'b0;
    end else if (aw_hs) begin
      w_addr    <= aw_addr_i;
      w_len     <= aw_len_i;
      w_cnt     <= '0;
      w_burst   <= aw_burst_i;
      w_id      <= aw_id_i;
      w_size_ok <= (aw_size_i == size_lp);
      w_slv     <= (aw_size_i != size_lp) || (aw_burst_i == 2'd3);
      w_dec     <= 1'b0;
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_len, w_burst);
      w_cnt  <= w_cnt + 8'd1;
      if (w_last_i != w_final) w_slv <= 1'b1;
      if (!in_range(w_addr))   w_dec <= 1'b1;
    end
  end

  // Byte-enabled array write; bad size or out-of-range beats leave memory untouched.
  always_ff @(posedge clk_i) begin
    if (w_hs && w_size_ok && in_range(w_addr)) begin
      for (int i = 0; i < bytes_lp; i++) begin
        if (w_strb_i[i]) mem[word_idx(w_addr)][i*8 +: 8] <= w_data_i[i*8 +: 8];
      end
    end
  end

  assign b_resp_o = reset_i ? 2'b00 : (w_dec ? 2'b11 : (w_slv ? 2'b10 : 2'b00));
  assign b_id_o   = reset_i ? '0 : w_id;

  // ---------------- read path ----------------
  r_state_e r_state, r_state_n;
  logic [addr_width_p-1:0] r_addr, ld_addr;
  logic [7:0]              r_len, r_cnt;
  logic [1:0]              r_burst;
  logic                    r_size_ok, r_slv, ld_size_ok, ld_slv;
  logic [data_width_p-1:0] r_data_q, ld_data;
  logic [1:0]              r_resp_q, ld_resp;
  logic                    r_last_q;
  logic [id_width_p-1:0]   r_id_q;
  logic                    ar_hs, r_hs;

  assign ar_hs = ar_valid_i & ar_ready_o;
  assign r_hs  = r_valid_o & r_ready_i;

  // Read state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= R_IDLE;
    else         r_state <= r_state_n;
  end

  // Read next-state and handshake outputs; the final accepted beat returns to idle.
  always_comb begin
    r_state_n  = r_state;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    if (!reset_i) begin
      case (r_state)
        R_IDLE: begin
          ar_ready_o = stall_ok;
          if (ar_valid_i && stall_ok) r_state_n = R_DATA;
        end
        R_DATA: begin
          r_valid_o = 1'b1;
          if (r_ready_i && r_last_q) r_state_n = R_IDLE;
        end
        default: r_state_n = R_IDLE;
      endcase
    end
  end

  // Address, data and response of the beat to be loaded next (first beat on AR).
  always_comb begin
    ld_addr    = next_addr(r_addr, r_len, r_burst);
    ld_size_ok = r_size_ok;
    ld_slv     = r_slv;
    if (ar_hs) begin
      ld_addr    = ar_addr_i;
      ld_size_ok = (ar_size_i == size_lp);
      ld_slv     = (ar_size_i != size_lp) || (ar_burst_i == 2'd3);
    end
    ld_data = '0;
    ld_resp = 2'b00;
    if (!in_range(ld_addr)) begin
      ld_resp = 2'b11;
    end else begin
      if (ld_slv)     ld_resp = 2'b10;
      if (ld_size_ok) ld_data = mem[word_idx(ld_addr)];
    end
  end

  // Registered beat payload: stable while presented, captured before any same-cycle write.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_burst   <= '0;
      r_size_ok <= 1'b0;
      r_slv     <= 1'b0;
      r_id_q    <= '0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      r_last_q  <= 1'b0;
    end else if (ar_hs) begin
      r_addr    <= ld_addr;
      r_len     <= ar_len_i;
      r_cnt     <= '0;
      r_burst   <= ar_burst_i;
      r_size_ok <= ld_size_ok;
      r_slv     <= ld_slv;
      r_id_q    <= ar_id_i;
      r_data_q  <= ld_data;
      r_resp_q  <= ld_resp;
      r_last_q  <= (ar_len_i == 8'd0);
    end else if (r_hs && !r_last_q) begin
      r_addr   <= ld_addr;
      r_cnt    <= r_cnt + 8'd1;
      r_data_q <= ld_data;
      r_resp_q <= ld_resp;
      r_last_q <= ((r_cnt + 8'd1) == r_len);
    end
  end

  assign r_data_o = reset_i ? '0 : r_data_q;
  assign r_resp_o = reset_i ? 2'b00 : r_resp_q;
  assign r_id_o   = reset_i ? '0 : r_id_q;
  assign r_last_o = r_valid_o & r_last_q;

endmodule
